// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//   Single-transfer SPI master (mode 0) for a 16-bit register-access frame
//   {rw, addr[6:0], data[7:0]}, sent MSB first. Each SCLK half-period is
//   CLK_DIV clk cycles. Read frames return the last 8 CIPO bits on rd_data.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present            req_ready  idle, accepting a request
//   req_rw     1 = write, 0 = read        req_addr   7-bit register address
//   req_data   write data (ignored for reads)
//   nCS        chip select, active low    SCLK       serial clock, idle low
//   COPI       serial data out            CIPO       serial data in (pre-synced)
//   rd_data    last read result           done       one-cycle completion pulse
//   busy       high whenever not idle
// -----------------------------------------------------------------------------
module spi_controller #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  input  logic       CIPO,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       busy
);

  generate
    if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("spi_controller: CLK_DIV must lie in 4..255");
    end
  endgenerate

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_div, w_div_next;
  logic [3:0]  r_bit, w_bit_next;
  logic [15:0] r_frame, w_frame_next;
  logic [7:0]  r_rx, w_rx_next;
  logic [7:0]  r_rd_data, w_rd_next;
  logic        r_done, w_done_next;
  logic        r_ncs, r_sclk, r_copi;
  logic        w_ncs_next, w_sclk_next, w_copi_next;
  logic        w_frame_active;
  logic        w_div_end;

  assign w_div_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_frame   <= '0;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_ncs     <= 1'b1;
      r_sclk    <= 1'b0;
      r_copi    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_bit     <= w_bit_next;
      r_frame   <= w_frame_next;
      r_rx      <= w_rx_next;
      r_rd_data <= w_rd_next;
      r_done    <= w_done_next;
      r_ncs     <= w_ncs_next;
      r_sclk    <= w_sclk_next;
      r_copi    <= w_copi_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div + 8'd1;
    w_bit_next   = r_bit;
    w_frame_next = r_frame;
    w_rx_next    = r_rx;
    w_rd_next    = r_rd_data;
    w_done_next  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_div_next = '0;
        if (req_valid) begin
          // Frame is captured here and never touched again, so input
          // changes during the transfer cannot leak into it.
          w_state_next = S_SETUP;
          w_frame_next = {req_rw, req_addr, req_data};
          w_bit_next   = '0;
        end
      end
      S_SETUP: begin
        if (w_div_end) begin
          w_state_next = S_HIGH;
          w_div_next   = '0;
        end
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_div_next = '0;
          // Sample as late as possible in the high phase.
          w_rx_next  = {r_rx[6:0], CIPO};
          if (r_bit == 4'd15) begin
            w_state_next = S_HOLD;
          end else begin
            w_state_next = S_LOW;
            w_bit_next   = r_bit + 4'd1;
          end
        end
      end
      S_LOW: begin
        if (w_div_end) begin
          w_state_next = S_HIGH;
          w_div_next   = '0;
        end
      end
      S_HOLD: begin
        if (w_div_end) begin
          w_state_next = S_GAP;
          w_div_next   = '0;
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_state_next = S_IDLE;
          w_div_next   = '0;
          w_done_next  = 1'b1;
          if (!r_frame[15]) begin
            w_rd_next = r_rx;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_div_next   = '0;
      end
    endcase

    // Pin values are registered from the next state so they switch on the
    // same edge as the state and are glitch-free. The bit index advances on
    // the edge that ends HIGH, so COPI moves together with SCLK falling.
    w_frame_active = (w_state_next == S_SETUP) || (w_state_next == S_HIGH) ||
                     (w_state_next == S_LOW)   || (w_state_next == S_HOLD);
    w_ncs_next     = !w_frame_active;
    w_sclk_next    = (w_state_next == S_HIGH);
    w_copi_next    = w_frame_active && w_frame_next[~w_bit_next];
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign nCS       = r_ncs;
  assign SCLK      = r_sclk;
  assign COPI      = r_copi;
  assign rd_data   = r_rd_data;
  assign done      = r_done;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
//   Directed + randomized checks of spi_controller against an SPI-level
//   peripheral model (register file fed by captured COPI bits, CIPO driven
//   after SCLK falling edges) and a bus monitor with protocol checks.
// -----------------------------------------------------------------------------
module tb_spi_controller;

  localparam int CLK_DIV = 8;
  localparam int FRAME_LOW = 33 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       nCS, SCLK, COPI;
  logic       CIPO = 1'b0;
  logic [7:0] rd_data;
  logic       done, busy;

  spi_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .CIPO(CIPO),
    .rd_data(rd_data), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Peripheral register file and bus monitor state
  logic [7:0]  mem [128];
  logic        prev_sclk = 1'b0, prev_copi = 1'b0, prev_ncs = 1'b1;
  logic        in_frame = 1'b0;
  logic [15:0] cap = '0;
  logic [6:0]  cur_addr = '0;
  int          rises = 0, low_len = 0, high_len = 0, last_gap = 0, proto_err = 0;
  logic [15:0] frm_q [$];
  int          rise_q [$];
  int          len_q [$];
  logic [7:0]  exp_rd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor / peripheral model, sampled on the falling clk edge.
  initial begin
    logic [7:0] byte_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        CIPO     = 1'b0;
      end else begin
        if (nCS && SCLK) proto_err++;
        if (SCLK && prev_sclk && (COPI !== prev_copi)) proto_err++;
        if (!nCS && prev_ncs) begin
          in_frame = 1'b1;
          cap      = '0;
          rises    = 0;
          low_len  = 0;
          last_gap = high_len;
        end
        if (nCS) high_len++; else high_len = 0;
        if (!nCS && in_frame) low_len++;
        if (in_frame && SCLK && !prev_sclk) begin
          cap = {cap[14:0], COPI};
          rises++;
          if (rises == 8) cur_addr = cap[6:0];
        end
        // Peripheral shifts out the addressed register after each fall
        if (in_frame && !SCLK && prev_sclk && rises >= 8 && rises <= 15) begin
          byte_v = mem[cur_addr];
          CIPO   = byte_v[15 - rises];
        end
        if (nCS && !prev_ncs && in_frame) begin
          in_frame = 1'b0;
          CIPO     = 1'b0;
          frm_q.push_back(cap);
          rise_q.push_back(rises);
          len_q.push_back(low_len);
          if (rises == 16 && cap[15]) mem[cap[14:8]] = cap[7:0];
        end
      end
      prev_sclk = SCLK;
      prev_copi = COPI;
      prev_ncs  = nCS;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] expf);
    if (frm_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_frame"}, {16'd0, frm_q.pop_front()}, {16'd0, expf});
      chk({tag, "_rises"}, rise_q.pop_front(), 32'd16);
      chk({tag, "_ncs_low"}, len_q.pop_front(), FRAME_LOW);
    end
  endtask

  task automatic xfer(input string tag, input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input bit scramble);
    if (!rw) exp_rd = mem[a];
    wait_ready();
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    if (scramble) begin
      req_rw   = ~rw;
      req_addr = 7'($urandom);
      req_data = 8'($urandom);
    end
    wait_done();
    chk({tag, "_ready_at_done"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, {24'd0, exp_rd});
    check_frame(tag, {rw, a, d});
    @(negedge clk);
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    chk({tag, "_proto"}, proto_err, 32'd0);
    $display("xfer %s rw=%0d addr=%02h data=%02h rd_data=%02h", tag, rw, a, d, rd_data);
  endtask

  initial begin
    int n;
    int dones;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[4] = 8'h3C;

    // Reset state
    #12;
    chk("rst_ncs", {31'd0, nCS}, 32'd1);
    chk("rst_sclk", {31'd0, SCLK}, 32'd0);
    chk("rst_copi", {31'd0, COPI}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed write, read and readback
    xfer("write_a5", 1'b1, 7'h02, 8'hA5, 1'b0);
    xfer("read_3c", 1'b0, 7'h04, 8'h00, 1'b0);
    xfer("read_back", 1'b0, 7'h02, 8'h5A, 1'b0);
    chk("readback_val", {24'd0, rd_data}, 32'hA5);

    // Back-to-back writes with req_valid held high
    wait_ready();
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 7'h00;
    req_data  = 8'hFF;
    @(negedge clk);
    chk("b2b_first_busy", {31'd0, busy}, 32'd1);
    req_addr = 7'h01;
    req_data = 8'h0F;
    wait_done();
    chk("b2b_ready_at_done", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("b2b_second_accepted", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    check_frame("b2b_1", 16'h80FF);
    wait_done();
    check_frame("b2b_2", 16'h810F);
    chk("b2b_gap", last_gap, 32'd9);
    chk("b2b_reg0", {24'd0, mem[0]}, 32'hFF);
    chk("b2b_reg1", {24'd0, mem[1]}, 32'h0F);
    $display("xfer b2b writes reg0=%02h reg1=%02h gap=%0d", mem[0], mem[1], last_gap);
    @(negedge clk);

    // Reset in the middle of a frame
    wait_ready();
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 7'h09;
    req_data  = 8'h55;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rises < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit6", rises, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ncs", {31'd0, nCS}, 32'd1);
    chk("abort_sclk", {31'd0, SCLK}, 32'd0);
    chk("abort_copi", {31'd0, COPI}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rd", {24'd0, rd_data}, 32'd0);
    exp_rd = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    chk("abort_no_frame", frm_q.size(), 32'd0);
    $display("xfer abort at bit 6, reset applied");
    xfer("after_abort_w", 1'b1, 7'h03, 8'h81, 1'b0);
    xfer("after_abort_r", 1'b0, 7'h03, 8'h00, 1'b0);
    chk("after_abort_val", {24'd0, rd_data}, 32'h81);
    xfer("aborted_reg", 1'b0, 7'h09, 8'h00, 1'b0);

    // Randomized transfers with input scrambling while busy
    for (int i = 0; i < 10; i++) begin
      xfer("rand", 1'($urandom), 7'($urandom), 8'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: SCLK half-period in clk cycles; legal range 4..255, rejected at elaboration outside range.
REQ-002 SHALL have port clk  input  1  system clock, single clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller idle and accepting a request.
REQ-006 SHALL have port req_rw  input  1  transfer type, 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  7  target register address.
REQ-008 SHALL have port req_data  input  8  write data; don't-care for reads.
REQ-009 SHALL have port nCS  output  1  chip select to peripheral, active low.
REQ-010 SHALL have port SCLK  output  1  serial clock, idle low (mode 0).
REQ-011 SHALL have port COPI  output  1  serial data to peripheral.
REQ-012 SHALL have port CIPO  input  1  serial data from peripheral, pre-synchronised externally.
REQ-013 SHALL have port rd_data  output  8  last read result.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL accept a request on a clk edge where req_valid and req_ready are both high, latching a 16-bit frame {req_rw, req_addr[6:0], req_data[7:0]}; req_ready SHALL be low from the next cycle until done.
REQ-017 SHALL implement FSM IDLE -> SETUP -> HIGH <-> LOW -> HOLD -> GAP -> IDLE, with a divide counter reloaded at every state entry.
REQ-018 IDLE: nCS=1, SCLK=0, COPI=0, req_ready=1; exits to SETUP on acceptance only.
REQ-019 SETUP: nCS=0, SCLK=0, COPI=frame bit 15, lasting CLK_DIV cycles, then HIGH.
REQ-020 HIGH: SCLK=1 for CLK_DIV cycles; CIPO sampled in the last HIGH cycle into a shift register; then LOW, or HOLD after the 16th HIGH phase.
REQ-021 LOW: SCLK=0 for CLK_DIV cycles; COPI SHALL advance to the next bit, MSB first, on the clk edge that ends HIGH, so COPI changes only while SCLK is low.
REQ-022 Frame SHALL have exactly 16 SCLK rising edges; nCS low for exactly 33*CLK_DIV clk cycles (1 setup + 16 high + 15 low + 1 hold phase).
REQ-023 HOLD: nCS=0, SCLK=0 for CLK_DIV cycles, then nCS=1 and GAP.
REQ-024 GAP: nCS=1, SCLK=0, COPI=0 for CLK_DIV cycles, then IDLE.
REQ-025 done SHALL pulse high for exactly the first IDLE cycle after GAP, with req_ready=1 in that same cycle, so back-to-back requests are accepted with nCS high for at least CLK_DIV+1 cycles.
REQ-026 For req_rw=0, rd_data SHALL update with the last 8 sampled CIPO bits (first sampled = bit 7) in the cycle done asserts.
REQ-027 For req_rw=1, rd_data SHALL hold its value.
REQ-028 Bit counter SHALL be 4 bits, from 0 to 15, with no wrap beyond 15; the divide counter width SHALL be 8 bits.
REQ-029 Address SHALL be sent unchecked; unmapped addresses are the peripheral's concern.
REQ-030 req_valid, req_rw, req_addr and req_data SHALL be ignored while busy; frame contents are immune to input changes after acceptance.

Reset
REQ-031 rst_n low SHALL immediately, without waiting for clk, force IDLE: nCS=1, SCLK=0, COPI=0, req_ready=1, done=0, busy=0, rd_data=8'h00, counters=0.
REQ-032 Reset mid-frame SHALL abort the frame with no done pulse; the first request after release SHALL start a fresh frame from bit 15.

Verification
REQ-033 Write: CLK_DIV=8, rw=1, addr=7'h02, data=8'hA5 -> COPI sampled at 16 SCLK rises = 16'h82A5; nCS low 264 cycles; one done pulse; rd_data unchanged.
REQ-034 Read: rw=0, addr=7'h04, peripheral model drives CIPO=8'h3C during bits 7..0 -> rd_data=8'h3C at done; COPI frame=16'h0400 plus data field.
REQ-035 Back-to-back: req_valid held high with two writes (addr 0 data 8'hFF, addr 1 data 8'h0F) -> second accepted in the done cycle; nCS high 9 cycles between frames; the receiver model updates both registers.
REQ-036 Protocol checker: COPI never changes while SCLK=1; SCLK=0 whenever nCS=1; exactly 16 rises per nCS low.
REQ-037 Reset mid-frame at bit 6 -> nCS=1 and SCLK=0 asynchronously; no done; next write (addr 3, data 8'h81) completes correctly.
REQ-038 Input stability: req_addr/req_data changed during busy -> transmitted frame equals the accepted values.
